// File: rtl/reaction_fsm.sv
// Reaction-time controller: WAIT delay before lighting the LED, then counts 1 ms ticks until stop.
// Optional feature macro RANDOM_DELAY_EN: LFSR-derived WAIT delay (1000-3047 ms) instead of FIXED_DELAY_MS.
module reaction_fsm #(
   parameter int MAX_MS         = 9999,
   parameter int FIXED_DELAY_MS = 2000
) (
   input  logic        ck,
   input  logic        reset,
   input  logic        one_ms,
   input  logic        start,
   input  logic        stop,
   output logic        clear,
   output logic        led,
   output logic [13:0] time_ms,
   output logic        valid,
   output logic        timeout,
   output logic        cheat,
   output logic        busy
);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_GO, S_DONE, S_CHEAT} state_t;

   localparam logic [13:0] MAX_V = 14'(MAX_MS);

   state_t      state_q, state_d;
   logic [11:0] delay_q, delay_d;
   logic [13:0] time_q, time_d;
   logic        clear_q, clear_d;
   logic        led_q, led_d;
   logic        valid_q, valid_d;
   logic        timeout_q, timeout_d;
   logic        cheat_q, cheat_d;
   logic        busy_q, busy_d;
   logic [11:0] load_val;
   logic [13:0] time_inc;
   logic        go_wait;

`ifdef RANDOM_DELAY_EN
   logic [11:0] lfsr_q, lfsr_d;

   // Left-shifting Galois form of x^12+x^6+x^4+x+1
   assign lfsr_d   = {lfsr_q[10:0], 1'b0} ^ (lfsr_q[11] ? 12'h053 : 12'h000);
   assign load_val = 12'd1000 + {1'b0, lfsr_q[10:0]};

   always_ff @(posedge ck or posedge reset) begin
      if (reset) lfsr_q <= 12'hACE;
      else       lfsr_q <= lfsr_d;
   end
`else
   assign load_val = 12'(FIXED_DELAY_MS);
`endif

   assign time_inc = (time_q >= MAX_V) ? MAX_V : time_q + 14'd1;

   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         delay_q   <= '0;
         time_q    <= '0;
         clear_q   <= 1'b0;
         led_q     <= 1'b0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         cheat_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         delay_q   <= delay_d;
         time_q    <= time_d;
         clear_q   <= clear_d;
         led_q     <= led_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         cheat_q   <= cheat_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      delay_d   = delay_q;
      time_d    = time_q;
      valid_d   = valid_q;
      timeout_d = timeout_q;
      clear_d   = 1'b0;
      go_wait   = 1'b0;
      case (state_q)
         S_IDLE: if (start) go_wait = 1'b1;
         S_WAIT: begin
            // stop outranks a coincident tick: pressing on the last tick is still a cheat
            if (stop) begin
               state_d = S_CHEAT;
               time_d  = '0;
            end else if (one_ms) begin
               delay_d = delay_q - 12'd1;
               if (delay_q == 12'd1) begin
                  state_d = S_GO;
                  clear_d = 1'b1;
               end
            end
         end
         S_GO: begin
            if (one_ms) time_d = time_inc;
            if (stop || (one_ms && time_inc == MAX_V)) begin
               state_d   = S_DONE;
               valid_d   = 1'b1;
               timeout_d = one_ms && (time_inc == MAX_V);
            end
         end
         S_DONE, S_CHEAT: if (start) go_wait = 1'b1;
         default: state_d = S_IDLE;
      endcase
      if (go_wait) begin
         state_d   = S_WAIT;
         delay_d   = load_val;
         time_d    = '0;
         valid_d   = 1'b0;
         timeout_d = 1'b0;
         clear_d   = 1'b1;
      end
      led_d   = (state_d == S_GO);
      busy_d  = (state_d == S_WAIT) || (state_d == S_GO);
      cheat_d = (state_d == S_CHEAT);
   end

   assign clear   = clear_q;
   assign led     = led_q;
   assign time_ms = time_q;
   assign valid   = valid_q;
   assign timeout = timeout_q;
   assign cheat   = cheat_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_reaction_fsm.sv
// Bench for reaction_fsm with FIXED_DELAY_MS=3, MAX_MS=5; one_ms driven as a pulse every 10 cycles.
module tb_reaction_fsm;

   typedef struct {
      logic [13:0] t;
      logic        to;
      logic        ch;
   } res_t;

   logic        ck = 1'b0;
   logic        reset = 1'b1;
   logic        one_ms = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        clear, led, valid, timeout, cheat, busy;
   logic [13:0] time_ms;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   clr_cnt = 0;
   logic prev_evt = 1'b0;
   res_t exp_q[$];
   res_t e;

   reaction_fsm #(.MAX_MS(5), .FIXED_DELAY_MS(3)) dut (
      .ck(ck), .reset(reset), .one_ms(one_ms), .start(start), .stop(stop),
      .clear(clear), .led(led), .time_ms(time_ms), .valid(valid),
      .timeout(timeout), .cheat(cheat), .busy(busy)
   );

   always #5 ck = ~ck;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // Scoreboard: each finished result (valid or cheat rising) pops one expectation
   always @(negedge ck) begin
      if (clear) clr_cnt++;
      if ((valid | cheat) && !prev_evt) begin
         if (exp_q.size() == 0) chk("sb_unexpected_result", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("sb_time", 32'(time_ms), 32'(e.t));
            chk("sb_timeout", 32'(timeout), 32'(e.to));
            chk("sb_cheat", 32'(cheat), 32'(e.ch));
            chk("sb_valid", 32'(valid), 32'(!e.ch));
         end
      end
      prev_evt = valid | cheat;
   end

   task automatic push(input int t, input bit to, input bit ch);
      res_t r;
      r.t = 14'(t); r.to = to; r.ch = ch;
      exp_q.push_back(r);
   endtask

   task automatic pulse_start();
      @(negedge ck); start = 1'b1;
      @(negedge ck); start = 1'b0;
   endtask

   task automatic pulse_stop();
      @(negedge ck); stop = 1'b1;
      @(negedge ck); stop = 1'b0;
   endtask

   task automatic tick(input bit with_stop);
      repeat (9) @(negedge ck);
      one_ms = 1'b1; stop = with_stop;
      @(negedge ck);
      one_ms = 1'b0; stop = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick(1'b0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_clear"}, 32'(clear), 0);
      chk({tag, "_led"}, 32'(led), 0);
      chk({tag, "_time"}, 32'(time_ms), 0);
      chk({tag, "_valid"}, 32'(valid), 0);
      chk({tag, "_timeout"}, 32'(timeout), 0);
      chk({tag, "_cheat"}, 32'(cheat), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, n_fail %0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge ck);
      chk_all_zero("rst");
      reset = 1'b0;
      repeat (2) @(negedge ck);
      clr_cnt = 0;

      // Normal measurement
      push(2, 0, 0);
      pulse_start();
      chk("norm_busy_wait", 32'(busy), 1);
      chk("norm_led_wait", 32'(led), 0);
      ticks(3);
      chk("norm_led_go", 32'(led), 1);
      tick(1'b0);
      chk("norm_led_t1", 32'(led), 1);
      chk("norm_time_t1", 32'(time_ms), 1);
      tick(1'b0);
      chk("norm_led_t2", 32'(led), 1);
      pulse_stop();
      chk("norm_time", 32'(time_ms), 2);
      chk("norm_valid", 32'(valid), 1);
      chk("norm_busy_done", 32'(busy), 0);
      chk("norm_led_done", 32'(led), 0);
      repeat (2) @(negedge ck);
      chk("norm_clear_pulses", 32'(clr_cnt), 2);
      tick(1'b0);
      chk("norm_hold_time", 32'(time_ms), 2);

      // Early press
      push(0, 0, 1);
      pulse_start();
      chk("early_valid_cleared", 32'(valid), 0);
      chk("early_time_cleared", 32'(time_ms), 0);
      tick(1'b0);
      pulse_stop();
      chk("early_cheat", 32'(cheat), 1);
      chk("early_led", 32'(led), 0);
      chk("early_time", 32'(time_ms), 0);
      chk("early_busy", 32'(busy), 0);
      pulse_start();
      chk("early_cheat_cleared", 32'(cheat), 0);
      chk("early_rewait_busy", 32'(busy), 1);

      // stop coinciding with the final WAIT tick
      push(0, 0, 1);
      ticks(2);
      tick(1'b1);
      chk("simwait_cheat", 32'(cheat), 1);
      chk("simwait_led", 32'(led), 0);

      // Timeout at MAX_MS
      push(5, 1, 0);
      pulse_start();
      ticks(3);
      ticks(4);
      chk("to_time4", 32'(time_ms), 4);
      chk("to_valid4", 32'(valid), 0);
      tick(1'b0);
      chk("to_time", 32'(time_ms), 5);
      chk("to_timeout", 32'(timeout), 1);
      chk("to_valid", 32'(valid), 1);
      chk("to_led", 32'(led), 0);
      ticks(2);
      chk("to_time_held", 32'(time_ms), 5);

      // stop coinciding with a GO tick at count 3
      push(4, 0, 0);
      pulse_start();
      ticks(3);
      ticks(3);
      tick(1'b1);
      chk("simgo_time", 32'(time_ms), 4);
      chk("simgo_valid", 32'(valid), 1);
      chk("simgo_timeout", 32'(timeout), 0);

      // Asynchronous reset mid-GO
      pulse_start();
      ticks(3);
      ticks(2);
      chk("rgo_time_before", 32'(time_ms), 2);
      #2 reset = 1'b1;
      #1 chk_all_zero("rgo");
      @(negedge ck); reset = 1'b0;
      push(2, 0, 0);
      clr_cnt = 0;
      pulse_start();
      chk("rgo_restart_busy", 32'(busy), 1);
      ticks(5);
      pulse_stop();
      chk("rgo_restart_time", 32'(time_ms), 2);
      chk("rgo_restart_valid", 32'(valid), 1);
      repeat (2) @(negedge ck);
      chk("rgo_clear_pulses", 32'(clr_cnt), 2);
      chk("sb_drained", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
